systolic_feed_ctrl: RTL

//   Sequencer for one DIMxDIM systolic matrix multiply. On start, pulses an accumulator clear,

---
 rtl/systolic_pkg.sv | 18 +
 rtl/step_counter.sv | 41 ++++
 rtl/systolic_feed_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array control path: sequencer state encoding and
// the drain-length rule used by the feed controller and the memA/memB skew benches.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_e;

  // Skew fill (DIM-1) + array propagation (DIM-1) + last-row pass (DIM).
  function automatic int drain_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Clearable up-counter used for FEED/DRAIN step counting and, with SAT=1,
// as a saturating performance counter.
module step_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_max;

  assign at_max = SAT && (&value_q);

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && !at_max) begin
      value_d = value_q + W'(1);
    end
  end

  // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for one DIMxDIM systolic multiply: clear, feed DIM rows, drain, done.
// Define SYSTOLIC_CTRL_PERF_EN to add the perf_cycles/perf_stalls counters.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int  DIM          = 8,
  parameter int  DRAIN_CYCLES = drain_cycles(DIM),
  localparam int AW           = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int CW           = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          feed_zero,
  output logic          fifo_en,
  output logic          mac_en,
  output logic          clr,
  output logic          busy,
  output logic          done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stalls
`endif
);

  state_e        state_q;
  logic [CW-1:0] cnt;
  logic          running;
  logic          step_ok;
  logic          last_step;

  assign running   = (state_q == FEED) || (state_q == DRAIN);
  assign step_ok   = running && !stall;
  assign last_step = ((state_q == FEED)  && (cnt == CW'(DIM - 1))) ||
                     ((state_q == DRAIN) && (cnt == CW'(DRAIN_CYCLES - 1)));

  // One counter serves both phases; it is zeroed on entry to FEED and to DRAIN.
  step_counter #(.W(CW), .SAT(1'b0)) u_step_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  ((state_q == CLEAR) || (step_ok && last_step)),
    .inc_i  (step_ok && !last_step),
    .value_o(cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= CLEAR;
        CLEAR:   state_q <= FEED;
        FEED:    if (step_ok && last_step) state_q <= DRAIN;
        DRAIN:   if (step_ok && last_step) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    feed_zero = 1'b0;
    fifo_en   = 1'b0;
    mac_en    = 1'b0;
    clr       = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    case (state_q)
      CLEAR: clr = 1'b1;
      FEED: begin
        rd_en   = !stall;
        rd_addr = cnt[AW-1:0];
        fifo_en = !stall;
        mac_en  = !stall;
      end
      DRAIN: begin
        feed_zero = 1'b1;
        fifo_en   = !stall;
        mac_en    = !stall;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  step_counter #(.W(32), .SAT(1'b1)) u_perf_cycles (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == CLEAR),
    .inc_i  (running),
    .value_o(perf_cycles)
  );

  step_counter #(.W(32), .SAT(1'b1)) u_perf_stalls (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == CLEAR),
    .inc_i  (running && stall),
    .value_o(perf_stalls)
  );
`endif

endmodule
